// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - sequential shift-and-add unsigned multiplier with start/done control FSM
//
// Computes p = a * b for WIDTH-bit unsigned operands, one partial product per
// clock. Fixed latency: done pulses WIDTH cycles after the accepted start.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled only while idle
//   a, b   multiplicand / multiplier, latched when start is accepted
//   busy   high from the accepted start until the cycle after done
//   done   one-cycle pulse when p holds a new product
//   p      product register, holds the last result until the next done

module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  // One extra bit so count can represent WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand, mcand_nxt;
  logic [WIDTH-1:0]     mplier, mplier_nxt;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [CW-1:0]        count, count_nxt;
  logic [2*WIDTH-1:0]   p_nxt;
  logic                 busy_nxt, done_nxt;
  logic [2*WIDTH-1:0]   acc_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      p      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      count  <= count_nxt;
      p      <= p_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    count_nxt  = count;
    p_nxt      = p;
    busy_nxt   = busy;
    done_nxt   = 1'b0;  // done is a single-cycle pulse

    // Partial product for this iteration; the full product always fits in 2*WIDTH bits.
    acc_sum = acc + (mplier[0] ? mcand : '0);

    case (state)
      S_IDLE: begin
        if (start) begin
          mcand_nxt  = {{WIDTH{1'b0}}, a};
          mplier_nxt = b;
          acc_nxt    = '0;
          count_nxt  = '0;
          busy_nxt   = 1'b1;
          state_nxt  = S_CALC;
        end
      end

      S_CALC: begin
        acc_nxt    = acc_sum;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        count_nxt  = count + CW'(1);
        // No early exit on mplier==0: latency stays fixed at WIDTH iterations.
        if (count == CW'(WIDTH - 1)) begin
          p_nxt     = acc_sum;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
